// File: rtl/rot_ahb_dma.sv
// rot_ahb_dma: single-channel AHB master DMA engine.
// Moves I_CMD_BEATS 32-bit words between memory (AHB master port) and either
// a read FIFO (memory read) or an external write source (memory write).
// Ports:
//   I_HCLK / I_HRESET_N       clock, async active-low reset
//   I_CMD_*  / O_CMD_READY    command handshake (direction, start address, beats)
//   O_DMA_* / I_DMA_*         AHB master (bus request/grant, address/data phases)
//   O_RD_DATA/VALID, I_RD_READY  read-FIFO output stream
//   I_WR_DATA/LEVEL, O_WR_POP    write-source head word, fill level, pop strobe
//   O_BUSY / O_DONE           activity flag and one-cycle completion pulse
module rot_ahb_dma #(
    parameter int BURST_BEATS   = 8,
    parameter int RD_FIFO_DEPTH = 32
) (
    input  logic        I_HCLK,
    input  logic        I_HRESET_N,
    input  logic        I_CMD_VALID,
    output logic        O_CMD_READY,
    input  logic        I_CMD_WRITE,
    input  logic [31:0] I_CMD_ADDR,
    input  logic [15:0] I_CMD_BEATS,
    output logic        O_DMA_HBUSREQ,
    input  logic        I_DMA_HGRANT,
    output logic [31:0] O_DMA_HADDR,
    output logic [1:0]  O_DMA_HTRANS,
    output logic [2:0]  O_DMA_HSIZE,
    output logic [3:0]  O_DMA_HBURST,
    output logic        O_DMA_HWRITE,
    output logic [31:0] O_DMA_HWDATA,
    input  logic [31:0] I_DMA_HRDATA,
    input  logic        I_DMA_HREADY,
    output logic [31:0] O_RD_DATA,
    output logic        O_RD_VALID,
    input  logic        I_RD_READY,
    input  logic [31:0] I_WR_DATA,
    input  logic [15:0] I_WR_LEVEL,
    output logic        O_WR_POP,
    output logic        O_BUSY,
    output logic        O_DONE
);

    localparam int AW = $clog2(RD_FIFO_DEPTH);
    localparam int AL = $clog2(BURST_BEATS * 4);
    localparam logic [3:0] INCR_CODE = (BURST_BEATS == 4)  ? 4'b0011 :
                                       (BURST_BEATS == 16) ? 4'b0111 : 4'b0101;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_XFER, ST_DRAIN, ST_DONE} state_t;

    state_t      state;
    logic [31:0] addr_q;      // start address of the next transfer
    logic [15:0] rem_q;       // beats not yet issued
    logic        write_q;
    logic [4:0]  beats_left;  // address phases left in the current transfer
    logic        dph_vld;     // a data phase is on the bus

    // read FIFO
    logic [31:0]   mem [RD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          push, pop;

    // transfer selection (evaluated while in REQ)
    logic        burst_ok, issue;
    logic [15:0] xfer_n;
    logic [16:0] rd_room;

    assign burst_ok = (rem_q >= 16'(BURST_BEATS)) && (addr_q[AL-1:0] == '0);
    assign xfer_n   = burst_ok ? 16'(BURST_BEATS) : 16'd1;
    // FIFO space must cover the whole transfer plus the data phase still in flight
    assign rd_room  = 17'(RD_FIFO_DEPTH) - 17'(fifo_cnt) - 17'(dph_vld && !write_q);
    assign issue    = write_q ? (I_WR_LEVEL >= xfer_n) : (rd_room >= {1'b0, xfer_n});

    assign push         = dph_vld && !write_q && I_DMA_HREADY;
    assign pop          = O_RD_VALID && I_RD_READY;
    assign O_RD_VALID   = (fifo_cnt != '0);
    assign O_RD_DATA    = O_RD_VALID ? mem[rd_ptr] : 32'd0;
    assign O_WR_POP     = dph_vld && write_q && I_DMA_HREADY;
    assign O_DMA_HWDATA = (dph_vld && write_q) ? I_WR_DATA : 32'd0;

    // data phase follows an accepted address phase; HREADY low freezes it
    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N)
            dph_vld <= 1'b0;
        else if (I_DMA_HREADY)
            dph_vld <= O_DMA_HTRANS[1];
    end

    always_ff @(posedge I_HCLK) begin
        if (push)
            mem[wr_ptr] <= I_DMA_HRDATA;
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            write_q       <= 1'b0;
            beats_left    <= '0;
            O_CMD_READY   <= 1'b0;
            O_DMA_HBUSREQ <= 1'b0;
            O_DMA_HADDR   <= '0;
            O_DMA_HTRANS  <= HT_IDLE;
            O_DMA_HSIZE   <= 3'b000;
            O_DMA_HBURST  <= 4'b0000;
            O_DMA_HWRITE  <= 1'b0;
            O_BUSY        <= 1'b0;
            O_DONE        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    O_CMD_READY <= 1'b1;
                    if (I_CMD_VALID && O_CMD_READY) begin
                        O_CMD_READY <= 1'b0;
                        addr_q      <= I_CMD_ADDR;
                        rem_q       <= I_CMD_BEATS;
                        write_q     <= I_CMD_WRITE;
                        if (I_CMD_BEATS == 16'd0) begin
                            state  <= ST_DONE;
                            O_DONE <= 1'b1;
                        end else begin
                            state         <= ST_REQ;
                            O_BUSY        <= 1'b1;
                            O_DMA_HBUSREQ <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (I_DMA_HGRANT && I_DMA_HREADY && issue) begin
                        state         <= ST_XFER;
                        O_DMA_HADDR   <= addr_q;
                        O_DMA_HTRANS  <= HT_NONSEQ;
                        O_DMA_HSIZE   <= 3'b010;
                        O_DMA_HBURST  <= burst_ok ? INCR_CODE : 4'b0000;
                        O_DMA_HWRITE  <= write_q;
                        beats_left    <= xfer_n[4:0];
                        addr_q        <= addr_q + {14'd0, xfer_n, 2'b00};
                        rem_q         <= rem_q - xfer_n;
                        // a single's only address phase is also its last one
                        O_DMA_HBUSREQ <= (xfer_n != 16'd1);
                    end else begin
                        // withdraw the request while the transfer cannot be issued
                        O_DMA_HBUSREQ <= issue;
                    end
                end
                ST_XFER: begin
                    // grant is ignored here: a started burst always completes
                    if (I_DMA_HREADY) begin
                        if (beats_left > 5'd1) begin
                            O_DMA_HADDR  <= O_DMA_HADDR + 32'd4;
                            O_DMA_HTRANS <= HT_SEQ;
                            beats_left   <= beats_left - 5'd1;
                            if (beats_left == 5'd2)
                                O_DMA_HBUSREQ <= 1'b0;
                        end else begin
                            O_DMA_HTRANS <= HT_IDLE;
                            if (rem_q != 16'd0) begin
                                state         <= ST_REQ;
                                O_DMA_HBUSREQ <= 1'b1;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!dph_vld || I_DMA_HREADY) begin
                        state        <= ST_DONE;
                        O_DONE       <= 1'b1;
                        O_BUSY       <= 1'b0;
                        O_DMA_HSIZE  <= 3'b000;
                        O_DMA_HBURST <= 4'b0000;
                        O_DMA_HWRITE <= 1'b0;
                    end
                end
                ST_DONE: begin
                    O_DONE      <= 1'b0;
                    O_CMD_READY <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_ahb_dma.sv
// Self-checking bench for rot_ahb_dma: directed scenarios plus randomized
// commands, bus stalls, grant gaps and read back-pressure, scored against an
// address-phase / data-order model built from the transfer rules.
module tb_rot_ahb_dma;

    localparam int BB = 8;

    logic        I_HCLK = 1'b0;
    logic        I_HRESET_N = 1'b0;
    logic        I_CMD_VALID = 1'b0;
    logic        O_CMD_READY;
    logic        I_CMD_WRITE = 1'b0;
    logic [31:0] I_CMD_ADDR = '0;
    logic [15:0] I_CMD_BEATS = '0;
    logic        O_DMA_HBUSREQ;
    logic        I_DMA_HGRANT = 1'b1;
    logic [31:0] O_DMA_HADDR;
    logic [1:0]  O_DMA_HTRANS;
    logic [2:0]  O_DMA_HSIZE;
    logic [3:0]  O_DMA_HBURST;
    logic        O_DMA_HWRITE;
    logic [31:0] O_DMA_HWDATA;
    logic [31:0] I_DMA_HRDATA;
    logic        I_DMA_HREADY = 1'b1;
    logic [31:0] O_RD_DATA;
    logic        O_RD_VALID;
    logic        I_RD_READY = 1'b1;
    logic [31:0] I_WR_DATA;
    logic [15:0] I_WR_LEVEL;
    logic        O_WR_POP;
    logic        O_BUSY;
    logic        O_DONE;

    rot_ahb_dma #(.BURST_BEATS(BB), .RD_FIFO_DEPTH(32)) dut (
        .I_HCLK(I_HCLK), .I_HRESET_N(I_HRESET_N),
        .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
        .I_CMD_WRITE(I_CMD_WRITE), .I_CMD_ADDR(I_CMD_ADDR), .I_CMD_BEATS(I_CMD_BEATS),
        .O_DMA_HBUSREQ(O_DMA_HBUSREQ), .I_DMA_HGRANT(I_DMA_HGRANT),
        .O_DMA_HADDR(O_DMA_HADDR), .O_DMA_HTRANS(O_DMA_HTRANS), .O_DMA_HSIZE(O_DMA_HSIZE),
        .O_DMA_HBURST(O_DMA_HBURST), .O_DMA_HWRITE(O_DMA_HWRITE), .O_DMA_HWDATA(O_DMA_HWDATA),
        .I_DMA_HRDATA(I_DMA_HRDATA), .I_DMA_HREADY(I_DMA_HREADY),
        .O_RD_DATA(O_RD_DATA), .O_RD_VALID(O_RD_VALID), .I_RD_READY(I_RD_READY),
        .I_WR_DATA(I_WR_DATA), .I_WR_LEVEL(I_WR_LEVEL), .O_WR_POP(O_WR_POP),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE)
    );

    always #5 I_HCLK = ~I_HCLK;

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  t;
        logic [3:0]  b;
    } ap_t;

    ap_t         exp_ap [$];
    logic [31:0] exp_rd [$];
    logic [31:0] exp_wd [$];

    int n_vec = 0, n_err = 0;
    int done_cnt = 0, ap_cnt = 0, pop_cnt = 0, stall_cnt = 0;
    int hr_mode = 0, rr_mode = 0, hr_low = 0;
    logic cur_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // AHB slave: returns rd_word(address) in the data phase
    logic        dp_vld;
    logic [31:0] dp_addr;
    always @(posedge I_HCLK or negedge I_HRESET_N) begin
        if (!I_HRESET_N) begin
            dp_vld  <= 1'b0;
            dp_addr <= '0;
        end else if (I_DMA_HREADY) begin
            dp_vld  <= O_DMA_HTRANS[1];
            dp_addr <= O_DMA_HADDR;
        end
    end
    assign I_DMA_HRDATA = dp_vld ? rd_word(dp_addr) : 32'd0;

    // write source: word array, consumed on O_WR_POP
    logic [31:0] wsrc [256];
    int wr_idx = 0, wr_tot = 0;
    always @(posedge I_HCLK) if (O_WR_POP) wr_idx <= wr_idx + 1;
    assign I_WR_DATA  = wsrc[wr_idx[7:0]];
    assign I_WR_LEVEL = 16'(wr_tot - wr_idx);

    // bus / sink condition drivers, changed just after the active edge
    always @(posedge I_HCLK) begin
        #1;
        if (hr_low > 0) begin
            I_DMA_HREADY = 1'b0;
            hr_low--;
        end else begin
            I_DMA_HREADY = (hr_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        I_DMA_HGRANT = (hr_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (rr_mode)
            0:       I_RD_READY = 1'b1;
            1:       I_RD_READY = 1'($urandom_range(0, 1));
            default: I_RD_READY = 1'b0;
        endcase
    end

    // monitor: values at the falling edge are those the next rising edge sees
    logic        stall_prev = 1'b0;
    logic [31:0] stall_addr;
    logic [1:0]  stall_trans;
    always @(negedge I_HCLK) begin
        ap_t e;
        logic [31:0] w;
        if (I_HRESET_N) begin
            if (stall_prev) begin
                chk("hold_haddr", O_DMA_HADDR, stall_addr);
                chk("hold_htrans", 32'(O_DMA_HTRANS), 32'(stall_trans));
            end
            stall_prev  = O_DMA_HTRANS[1] && !I_DMA_HREADY;
            stall_addr  = O_DMA_HADDR;
            stall_trans = O_DMA_HTRANS;
            if (stall_prev) stall_cnt++;
            if (O_DMA_HTRANS[1] && I_DMA_HREADY) begin
                ap_cnt++;
                if (exp_ap.size() != 0) e = exp_ap.pop_front();
                else e = '{a: ~O_DMA_HADDR, t: 2'b00, b: 4'hF};
                chk("ap_haddr", O_DMA_HADDR, e.a);
                chk("ap_htrans", 32'(O_DMA_HTRANS), 32'(e.t));
                chk("ap_hburst", 32'(O_DMA_HBURST), 32'(e.b));
                chk("ap_hsize", 32'(O_DMA_HSIZE), 32'd2);
                chk("ap_hwrite", 32'(O_DMA_HWRITE), 32'(cur_wr));
            end
            if (O_WR_POP) begin
                pop_cnt++;
                w = (exp_wd.size() != 0) ? exp_wd.pop_front() : ~O_DMA_HWDATA;
                chk("hwdata", O_DMA_HWDATA, w);
            end
            if (O_RD_VALID && I_RD_READY) begin
                w = (exp_rd.size() != 0) ? exp_rd.pop_front() : ~O_RD_DATA;
                chk("rd_data", O_RD_DATA, w);
            end
            if (O_DONE) begin
                done_cnt++;
                chk("busy_in_done", 32'(O_BUSY), 32'd0);
            end
        end
    end

    // build the expected address phases and data from the transfer rules
    task automatic start_cmd(input logic wr, input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int r, n;
        cur_wr = wr; done_cnt = 0; ap_cnt = 0; pop_cnt = 0;
        a = addr; r = beats;
        while (r > 0) begin
            if (r >= BB && (a % (BB * 4)) == 0) begin
                for (int i = 0; i < BB; i++)
                    exp_ap.push_back('{a: a + 32'(4 * i), t: (i == 0) ? 2'b10 : 2'b11, b: 4'b0101});
                a = a + 32'(BB * 4); r = r - BB;
            end else begin
                exp_ap.push_back('{a: a, t: 2'b10, b: 4'b0000});
                a = a + 32'd4; r = r - 1;
            end
        end
        for (int i = 0; i < beats; i++) begin
            if (wr) begin
                wsrc[(wr_tot + i) % 256] = $urandom;
                exp_wd.push_back(wsrc[(wr_tot + i) % 256]);
            end else begin
                exp_rd.push_back(rd_word(addr + 32'(4 * i)));
            end
        end
        if (wr) wr_tot = wr_tot + beats;
        @(posedge I_HCLK); #1;
        I_CMD_VALID = 1'b1; I_CMD_WRITE = wr; I_CMD_ADDR = addr; I_CMD_BEATS = 16'(beats);
        n = 0;
        do begin @(negedge I_HCLK); n++; end while (!O_CMD_READY && n < 100);
        chk("cmd_accept", 32'(O_CMD_READY), 32'd1);
        @(posedge I_HCLK); #1;
        I_CMD_VALID = 1'b0;
    endtask

    task automatic finish_cmd();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 6000) begin @(negedge I_HCLK); n++; end
        repeat (3) @(negedge I_HCLK);
        n = 0;
        while (exp_rd.size() != 0 && n < 3000) begin @(negedge I_HCLK); n++; end
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("ap_left", 32'(exp_ap.size()), 32'd0);
        chk("wd_left", 32'(exp_wd.size()), 32'd0);
        chk("rd_left", 32'(exp_rd.size()), 32'd0);
        chk("busy_after", 32'(O_BUSY), 32'd0);
    endtask

    logic [31:0] ctl_bits;
    assign ctl_bits = {17'd0, O_DMA_HTRANS, O_DMA_HBURST, O_DMA_HSIZE, O_DMA_HWRITE,
                       O_DMA_HBUSREQ, O_RD_VALID, O_BUSY, O_DONE, O_WR_POP};

    initial begin
        int n, lat;
        logic [31:0] a;
        // reset state
        repeat (3) @(posedge I_HCLK); #1;
        chk("rst_ctl", ctl_bits, 32'd0);
        chk("rst_haddr", O_DMA_HADDR, 32'd0);
        chk("rst_ready", 32'(O_CMD_READY), 32'd0);
        @(negedge I_HCLK) I_HRESET_N = 1'b1;
        @(posedge I_HCLK); #1;
        chk("ready_after_rst", 32'(O_CMD_READY), 32'd1);

        // read 20 beats at 0x100: INCR8, INCR8, 4 singles
        start_cmd(1'b0, 32'h100, 20);
        @(negedge I_HCLK) chk("busy_running", 32'(O_BUSY), 32'd1);
        finish_cmd();
        chk("rd20_ap_cnt", 32'(ap_cnt), 32'd20);

        // write 9 beats at 0x104: all singles
        start_cmd(1'b1, 32'h104, 9);
        finish_cmd();
        chk("wr9_pops", 32'(pop_cnt), 32'd9);

        // zero-beat command
        start_cmd(1'b0, 32'h40, 0);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge I_HCLK);
            chk("zero_htrans", 32'(O_DMA_HTRANS), 32'd0);
            if (O_DONE && lat == 0) lat = i;
        end
        chk("zero_done_lat", 32'(lat >= 1 && lat <= 2), 32'd1);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // 3-cycle HREADY stall inside an INCR8
        start_cmd(1'b0, 32'h300, 8);
        stall_cnt = 0;
        n = 0;
        while (O_DMA_HTRANS != 2'b11 && n < 200) begin @(negedge I_HCLK); n++; end
        hr_low = 3;
        finish_cmd();
        chk("stall_cycles", 32'(stall_cnt), 32'd3);
        chk("stall_ap_cnt", 32'(ap_cnt), 32'd8);

        // read back-pressure: 64 beats with sink blocked stops at FIFO depth
        rr_mode = 2;
        start_cmd(1'b0, 32'h800, 64);
        repeat (200) @(negedge I_HCLK);
        chk("bp_ap_cnt", 32'(ap_cnt), 32'd32);
        chk("bp_busreq", 32'(O_DMA_HBUSREQ), 32'd0);
        chk("bp_htrans", 32'(O_DMA_HTRANS), 32'd0);
        rr_mode = 1;
        finish_cmd();
        chk("bp_total", 32'(ap_cnt), 32'd64);
        rr_mode = 0;

        // burst across the top of the address space
        start_cmd(1'b0, 32'hFFFF_FFE0, 12);
        finish_cmd();

        // randomized commands with stalls, grant gaps and back-pressure
        for (int k = 0; k < 24; k++) begin
            hr_mode = int'($urandom_range(0, 1));
            rr_mode = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 1) == 1) a = a & ~32'h1F;
            start_cmd(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 40)));
            finish_cmd();
        end
        hr_mode = 0; rr_mode = 0;

        // reset in the middle of a burst
        start_cmd(1'b0, 32'h400, 64);
        n = 0;
        while (O_DMA_HTRANS != 2'b11 && n < 200) begin @(negedge I_HCLK); n++; end
        #2 I_HRESET_N = 1'b0;
        #1;
        chk("abort_ctl", ctl_bits, 32'd0);
        chk("abort_haddr", O_DMA_HADDR, 32'd0);
        chk("abort_hwdata", O_DMA_HWDATA, 32'd0);
        chk("abort_rdata", O_RD_DATA, 32'd0);
        chk("abort_ready", 32'(O_CMD_READY), 32'd0);
        exp_ap.delete(); exp_rd.delete(); exp_wd.delete();
        done_cnt = 0;
        repeat (2) @(posedge I_HCLK);
        @(negedge I_HCLK) I_HRESET_N = 1'b1;
        @(posedge I_HCLK); #1;
        chk("abort_ready_rel", 32'(O_CMD_READY), 32'd1);
        chk("abort_fifo_empty", 32'(O_RD_VALID), 32'd0);
        repeat (20) @(negedge I_HCLK);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // engine works normally after the abort
        start_cmd(1'b1, 32'h500, 17);
        finish_cmd();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
